// File: rtl/adc_frame_aligner_if.sv
// adc_frame_aligner_if: serial ADC lane inputs and aligned parallel sample outputs
interface adc_frame_aligner_if #(
    parameter int ADC_CHANEL  = 8,
    parameter int SAMPLE_BITS = 14
);
    logic [1:0]                          fco_ddr;
    logic [2*ADC_CHANEL-1:0]             data_ddr;
    logic                                realign;
    logic [ADC_CHANEL*SAMPLE_BITS-1:0]   sample_data;
    logic                                sample_valid;
    logic                                locked;
    logic [$clog2(SAMPLE_BITS)-1:0]      bit_offset;
    logic                                frame_err;
    logic                                lock_lost;

    modport master (
        output fco_ddr, data_ddr, realign,
        input  sample_data, sample_valid, locked, bit_offset, frame_err, lock_lost
    );

    modport slave (
        input  fco_ddr, data_ddr, realign,
        output sample_data, sample_valid, locked, bit_offset, frame_err, lock_lost
    );
endinterface

// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner: FCO-guided bit-slip aligner and deserializer for AD9252 LVDS lanes
module adc_frame_aligner #(
    parameter int                     ADC_CHANEL  = 8,
    parameter int                     SAMPLE_BITS = 14,
    parameter logic [SAMPLE_BITS-1:0] FCO_PATTERN = 14'h3F80,
    parameter int                     LOCK_FRAMES = 16,
    parameter int                     ERR_FRAMES  = 4
) (
    input logic                clk,
    input logic                rst_n,
    adc_frame_aligner_if.slave bus
);
    localparam int F  = SAMPLE_BITS / 2;
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam int OW = $clog2(SAMPLE_BITS);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int EW = $clog2(ERR_FRAMES + 1);
    // newest 2*S-1 bits: the widest window any offset can reach
    localparam int HW = 2 * SAMPLE_BITS - 1;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]                        state;
    logic [CW-1:0]                     cnt;
    logic [OW-1:0]                     off;
    logic [OW-1:0]                     off_inc;
    logic [GW-1:0]                     good;
    logic [EW-1:0]                     err;
    logic [1:0]                        warm;
    logic [HW-3:0]                     fco_hist;
    logic [HW-1:0]                     fco_next;
    logic [HW-3:0]                     lane_hist [ADC_CHANEL];
    logic [HW-1:0]                     lane_next [ADC_CHANEL];
    logic [ADC_CHANEL*SAMPLE_BITS-1:0] words;
    logic [ADC_CHANEL*SAMPLE_BITS-1:0] data_q;
    logic [SAMPLE_BITS-1:0]            fco_word;
    logic                              boundary;
    logic                              active;
    logic                              match;
    logic                              valid_q;
    logic                              ferr_q;
    logic                              lost_q;

    // the rising (earlier) bit lands above the falling bit, newest bit at the LSB
    assign fco_next = {fco_hist, bus.fco_ddr};
    assign fco_word = SAMPLE_BITS'(fco_next >> off);

    for (genvar g = 0; g < ADC_CHANEL; g++) begin : g_lane
        assign lane_next[g] = {lane_hist[g], bus.data_ddr[2*g +: 2]};
        assign words[g*SAMPLE_BITS +: SAMPLE_BITS] = SAMPLE_BITS'(lane_next[g] >> off);
    end

    assign boundary = cnt == CW'(F - 1);
    assign active   = boundary && warm == 2'd2 && !bus.realign;
    assign match    = fco_word == FCO_PATTERN;
    assign off_inc  = (off == OW'(SAMPLE_BITS - 1)) ? '0 : off + 1'b1;

    assign bus.sample_data  = data_q;
    assign bus.sample_valid = valid_q;
    assign bus.locked       = state == LOCKED;
    assign bus.bit_offset   = off;
    assign bus.frame_err    = ferr_q;
    assign bus.lock_lost    = lost_q;

    // shift two new bits per cycle into every lane history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fco_hist <= '0;
            for (int i = 0; i < ADC_CHANEL; i++) lane_hist[i] <= '0;
        end else begin
            fco_hist <= fco_next[HW-3:0];
            for (int i = 0; i < ADC_CHANEL; i++) lane_hist[i] <= lane_next[i][HW-3:0];
        end
    end

    // free-running frame counter; the first two boundaries only fill the history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            warm <= '0;
        end else begin
            cnt <= boundary ? '0 : cnt + 1'b1;
            if (boundary && warm != 2'd2) warm <= warm + 1'b1;
        end
    end

    // lock search with hysteresis, slip offset on failure, publish words while locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            off     <= '0;
            good    <= '0;
            err     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            lost_q  <= 1'b0;
            if (bus.realign) begin
                state <= SEARCH;
                good  <= '0;
                err   <= '0;
            end else if (active) begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            state <= VERIFY;
                            good  <= GW'(1);
                        end else begin
                            off <= off_inc;
                        end
                    end
                    VERIFY: begin
                        if (!match) begin
                            state <= SEARCH;
                            good  <= '0;
                            off   <= off_inc;
                        end else begin
                            good <= good + 1'b1;
                            if (good == GW'(LOCK_FRAMES - 1)) state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        valid_q <= 1'b1;
                        data_q  <= words;
                        if (match) begin
                            err <= '0;
                        end else begin
                            ferr_q <= 1'b1;
                            err    <= err + 1'b1;
                            if (err == EW'(ERR_FRAMES - 1)) begin
                                state  <= SEARCH;
                                lost_q <= 1'b1;
                                err    <= '0;
                                good   <= '0;
                                off    <= off_inc;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule
